// File: rtl/pixel_decoder.sv
// pixel_decoder: receive side of the single-wire pulse-width pixel protocol.
// Synchronizes the serial line, classifies each high pulse as a 0/1 bit by its
// width, assembles 24-bit colors MSB first, and detects the long-low frame
// reset. Events are offered to the consumer over a single-entry valid/ready
// output.
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous, active-high reset
//   i_data_in    serial pixel line (asynchronous to i_clk)
//   o_color      decoded color, bit 23 = first bit received
//   o_is_reset   qualifies o_valid: 1 = frame-reset event, 0 = pixel
//   o_valid      event available, held until accepted
//   i_ready      consumer accepts the event when o_valid && i_ready
//   o_overrun    sticky: an event was dropped because the output was full
//   o_frame_err  sticky: a frame reset arrived with a partial pixel
//   i_err_clear  clears o_overrun and o_frame_err
//
// Configuration:
//   PIXEL_DECODER_GLITCH_FILTER_EN  when defined, high pulses shorter than
//   MIN_HI synced cycles produce no bit (MIN_HI exists only in that build).
module pixel_decoder #(
   parameter int unsigned TCK_BITS  = 10,
   parameter int unsigned THRESH    = 14,
   parameter int unsigned RESET_TCK = 400
`ifdef PIXEL_DECODER_GLITCH_FILTER_EN
   ,
   parameter int unsigned MIN_HI    = 3
`endif
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_data_in,
   output logic [23:0] o_color,
   output logic        o_is_reset,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_overrun,
   output logic        o_frame_err,
   input  logic        i_err_clear
);

   localparam int unsigned COLOR_W   = 24;
   localparam int unsigned BIT_CNT_W = 5;
   localparam logic [TCK_BITS-1:0]  CNT_MAX  = '1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(COLOR_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2
   } state_t;

   // Synchronizer and FSM datapath registers
   logic                 r_sync1;
   logic                 r_din_s;
   state_t               r_state;
   logic [TCK_BITS-1:0]  r_hi_cnt;
   logic [TCK_BITS-1:0]  r_lo_cnt;
   logic [COLOR_W-2:0]   r_shreg;
   logic [BIT_CNT_W-1:0] r_bit_cnt;

   // Output registers
   logic [COLOR_W-1:0]   r_color;
   logic                 r_is_reset;
   logic                 r_valid;
   logic                 r_overrun;
   logic                 r_frame_err;

   // Next-state / event wires
   state_t               w_state_nxt;
   logic [TCK_BITS-1:0]  w_hi_nxt;
   logic [TCK_BITS-1:0]  w_lo_nxt;
   logic [COLOR_W-2:0]   w_shreg_nxt;
   logic [BIT_CNT_W-1:0] w_bit_cnt_nxt;
   logic                 w_bit;
   logic                 w_glitch;
   logic                 w_evt;
   logic                 w_evt_is_reset;
   logic [COLOR_W-1:0]   w_evt_color;
   logic                 w_frame_err_set;
   logic                 w_drop;

   assign w_bit       = (r_hi_cnt >= TCK_BITS'(THRESH));
   assign w_evt_color = {r_shreg, w_bit};

`ifdef PIXEL_DECODER_GLITCH_FILTER_EN
   assign w_glitch = (r_hi_cnt < TCK_BITS'(MIN_HI));
`else
   assign w_glitch = 1'b0;
`endif

   // Two-flop synchronizer for the asynchronous serial line
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= 1'b0;
         r_din_s <= 1'b0;
      end else begin
         r_sync1 <= i_data_in;
         r_din_s <= r_sync1;
      end
   end

   // FSM state and datapath registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_hi_cnt  <= '0;
         r_lo_cnt  <= '0;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_hi_cnt  <= w_hi_nxt;
         r_lo_cnt  <= w_lo_nxt;
         r_shreg   <= w_shreg_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
      end
   end

   // Next-state logic: pulse measurement, bit decode, frame-reset detection
   always_comb begin
      w_state_nxt     = r_state;
      w_hi_nxt        = r_hi_cnt;
      w_lo_nxt        = r_lo_cnt;
      w_shreg_nxt     = r_shreg;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_evt           = 1'b0;
      w_evt_is_reset  = 1'b0;
      w_frame_err_set = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (r_din_s) begin
               w_state_nxt = S_HIGH;
               w_hi_nxt    = TCK_BITS'(1);
            end
         end

         S_HIGH: begin
            if (r_din_s) begin
               if (r_hi_cnt != CNT_MAX) w_hi_nxt = r_hi_cnt + TCK_BITS'(1);
            end else begin
               w_state_nxt = S_LOW;
               w_lo_nxt    = TCK_BITS'(1);
               if (!w_glitch) begin
                  if (r_bit_cnt == LAST_BIT) begin
                     w_evt         = 1'b1;
                     w_bit_cnt_nxt = '0;
                  end else begin
                     w_shreg_nxt   = {r_shreg[COLOR_W-3:0], w_bit};
                     w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                  end
               end
            end
         end

         S_LOW: begin
            if (r_din_s) begin
               w_state_nxt = S_HIGH;
               w_hi_nxt    = TCK_BITS'(1);
            end else if (r_lo_cnt == TCK_BITS'(RESET_TCK - 1)) begin
               // This cycle completes RESET_TCK consecutive low cycles
               w_evt           = 1'b1;
               w_evt_is_reset  = 1'b1;
               w_frame_err_set = (r_bit_cnt != '0);
               w_bit_cnt_nxt   = '0;
               w_state_nxt     = S_IDLE;
            end else if (r_lo_cnt != CNT_MAX) begin
               w_lo_nxt = r_lo_cnt + TCK_BITS'(1);
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // An event is dropped only when the held entry is not being accepted now
   assign w_drop = w_evt & r_valid & ~i_ready;

   // Single-entry output stage and sticky error flags
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_color     <= '0;
         r_is_reset  <= 1'b0;
         r_valid     <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_evt && !w_drop) begin
            r_valid    <= 1'b1;
            r_is_reset <= w_evt_is_reset;
            // Color is don't-care for reset events; keep the last pixel
            if (!w_evt_is_reset) r_color <= w_evt_color;
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end

         // A new error wins over a simultaneous clear
         if (w_drop)                r_overrun <= 1'b1;
         else if (i_err_clear)      r_overrun <= 1'b0;

         if (w_frame_err_set)       r_frame_err <= 1'b1;
         else if (i_err_clear)      r_frame_err <= 1'b0;
      end
   end

   assign o_color     = r_color;
   assign o_is_reset  = r_is_reset;
   assign o_valid     = r_valid;
   assign o_overrun   = r_overrun;
   assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_pixel_decoder.sv
// Self-checking bench for pixel_decoder: expected events are queued when the
// stimulus is driven and compared when the consumer accepts them.
module tb_pixel_decoder;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_data_in;
   logic [23:0] o_color;
   logic        o_is_reset;
   logic        o_valid;
   logic        i_ready;
   logic        o_overrun;
   logic        o_frame_err;
   logic        i_err_clear;

   typedef struct packed {
      logic        is_reset;
      logic [23:0] color;
   } evt_t;

   evt_t sb_q[$];
   evt_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   pixel_decoder dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_data_in   (i_data_in),
      .o_color     (o_color),
      .o_is_reset  (o_is_reset),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_overrun   (o_overrun),
      .o_frame_err (o_frame_err),
      .i_err_clear (i_err_clear)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bits(input logic [31:0] v, input int n, input int hi1, input int hi0);
      int hi;
      for (int i = n - 1; i >= 0; i--) begin
         hi = v[i] ? hi1 : hi0;
         i_data_in = 1'b1;
         tick(hi);
         i_data_in = 1'b0;
         tick(40 - hi);
      end
   endtask

   task automatic send_low(input int n);
      i_data_in = 1'b0;
      tick(n);
   endtask

   task automatic push_evt(input logic is_rst, input logic [23:0] c);
      evt_t e;
      e.is_reset = is_rst;
      e.color    = c;
      sb_q.push_back(e);
   endtask

   // Pixel followed by a frame reset, consumer always ready
   task automatic send_frame(input logic [23:0] c, input int hi1, input int hi0, input logic [23:0] exp_c);
      push_evt(1'b0, exp_c);
      push_evt(1'b1, 24'h0);
      send_bits(32'(c), 24, hi1, hi0);
      send_low(450);
   endtask

   // Monitor: on the falling edge, valid && ready means acceptance at the next rising edge
   always @(negedge clk) begin
      if (!i_reset && o_valid && i_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_evt", 32'(sb_q.size()), 32'd1);
         end else begin
            mon_e = sb_q.pop_front();
            check("evt_is_reset", 32'(o_is_reset), 32'(mon_e.is_reset));
            if (!mon_e.is_reset) check("evt_color", 32'(o_color), 32'(mon_e.color));
         end
      end
   end

   initial begin
      logic [24:0] glitch_bits;
      int          wait_cnt;

      i_reset     = 1'b1;
      i_data_in   = 1'b0;
      i_ready     = 1'b1;
      i_err_clear = 1'b0;
      tick(3);
      check("rst_color",     32'(o_color),     32'h0);
      check("rst_is_reset",  32'(o_is_reset),  32'h0);
      check("rst_valid",     32'(o_valid),     32'h0);
      check("rst_overrun",   32'(o_overrun),   32'h0);
      check("rst_frame_err", 32'(o_frame_err), 32'h0);
      i_reset = 1'b0;
      tick(2);

      // Basic pixel then frame reset
      push_evt(1'b0, 24'hA5C30F);
      push_evt(1'b1, 24'h0);
      send_bits(32'h00A5C30F, 24, 20, 8);
      send_low(800);
      check("t2_valid_idle", 32'(o_valid), 32'h0);

      // Threshold: 14 high cycles decode as 1, 13 as 0
      send_frame(24'h800000, 14, 13, 24'h800000);
      send_frame(24'h000000, 14, 13, 24'h000000);
      send_frame(24'hFFFFFF, 14, 13, 24'hFFFFFF);

      // Back-to-back pixels with consumer stalled: second is dropped
      i_ready = 1'b0;
      push_evt(1'b0, 24'h123456);
      send_bits(32'h00123456, 24, 20, 8);
      send_bits(32'h00FFFFFF, 24, 20, 8);
      tick(5);
      check("t3_hold_valid",   32'(o_valid),    32'h1);
      check("t3_hold_color",   32'(o_color),    32'h123456);
      check("t3_hold_isreset", 32'(o_is_reset), 32'h0);
      check("t3_overrun_set",  32'(o_overrun),  32'h1);
      push_evt(1'b1, 24'h0);
      i_ready = 1'b1;
      tick(5);
      check("t3_valid_clear",  32'(o_valid),    32'h0);
      check("t3_overrun_sticky", 32'(o_overrun), 32'h1);
      i_err_clear = 1'b1;
      tick(1);
      i_err_clear = 1'b0;
      check("t3_overrun_clear", 32'(o_overrun), 32'h0);
      send_low(450);

      // Partial pixel then frame reset
      check("t4_frame_err_pre", 32'(o_frame_err), 32'h0);
      push_evt(1'b1, 24'h0);
      send_bits(32'h000003A5, 10, 20, 8);
      send_low(400);
      tick(5);
      check("t4_frame_err_set", 32'(o_frame_err), 32'h1);
      send_frame(24'h00FF00, 20, 8, 24'h00FF00);
      check("t4_frame_err_sticky", 32'(o_frame_err), 32'h1);
      check("t4_overrun_clean", 32'(o_overrun), 32'h0);

      // Reset mid-pixel
      send_bits(32'h000002CB, 10, 20, 8);
      i_reset = 1'b1;
      tick(2);
      check("t1_color",     32'(o_color),     32'h0);
      check("t1_is_reset",  32'(o_is_reset),  32'h0);
      check("t1_valid",     32'(o_valid),     32'h0);
      check("t1_overrun",   32'(o_overrun),   32'h0);
      check("t1_frame_err", 32'(o_frame_err), 32'h0);
      i_reset = 1'b0;
      tick(2);
      send_frame(24'h5A3C96, 20, 8, 24'h5A3C96);
      check("t1_frame_err_after", 32'(o_frame_err), 32'h0);

      // Short glitch between bit 11 and bit 12
      glitch_bits = {12'hABC, 1'b0, 12'hDEF};
`ifdef PIXEL_DECODER_GLITCH_FILTER_EN
      push_evt(1'b0, 24'hABCDEF);
`else
      push_evt(1'b0, glitch_bits[24:1]);
`endif
      push_evt(1'b1, 24'h0);
      send_bits(32'h00000ABC, 12, 20, 8);
      i_data_in = 1'b1;
      tick(2);
      i_data_in = 1'b0;
      tick(20);
      send_bits(32'h00000DEF, 12, 20, 8);
      send_low(450);
`ifdef PIXEL_DECODER_GLITCH_FILTER_EN
      check("t6_frame_err", 32'(o_frame_err), 32'h0);
`else
      check("t6_frame_err", 32'(o_frame_err), 32'h1);
`endif

      // Drain with a bounded wait
      wait_cnt = 0;
      while (sb_q.size() != 0 && wait_cnt < 2000) begin
         tick(1);
         wait_cnt++;
      end
      check("sb_drain", 32'(sb_q.size()), 32'h0);
      check("end_valid", 32'(o_valid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
